led_receiver: RTL and testbench
===============================

LED_RECEIVER -- requirements
Module: led_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on all link inputs (min 2).
REQ-002 SHALL have parameter DIGITS, default 8, decimal digits per frame.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain for all logic.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clk_in  input  1  link digit clock from the display transmitter (asynchronous to clk).
REQ-006 SHALL have port cclr_neg  input  1  link counter clear, active-low, frame-start marker.
REQ-007 SHALL have port num  input  4  link BCD digit.
REQ-008 SHALL have port value  output  32  last good frame as unsigned binary, zero-extended.
REQ-009 SHALL have port digits  output  32  last good frame as BCD, digit 0 (most significant) in [31:28].
REQ-010 SHALL have port value_valid  output  1  one-clk pulse when value/digits update.
REQ-011 SHALL have port frame_err  output  1  one-clk pulse on a discarded frame.
REQ-012 SHALL have port locked  output  1  level, high once frame alignment is acquired.

Function
REQ-013 SHALL pass clk_in, cclr_neg and num through identical SYNC_STAGES flop chains so that all three stay aligned.
REQ-014 SHALL sample synchronized cclr_neg/num only on a detected falling edge of synchronized clk_in (a "sample"); the transmitter changes data on rising edges.
REQ-015 SHALL implement receive FSM states IDLE, ARM, RECV.
REQ-016 IDLE: sample with cclr_neg=0 -> ARM; all other samples ignored.
REQ-017 ARM: sample with cclr_neg=0 -> stay in ARM; first sample with cclr_neg=1 is discarded (stale num) -> RECV with idx=0, locked=1.
REQ-018 RECV: each sample with cclr_neg=1 stores num into capture buffer slot idx; idx increments 0..DIGITS-1 and wraps to 0 with no new clear (the transmitter repeats frames continuously).
REQ-019 RECV: sample with cclr_neg=0 -> abort partial frame, ARM; frame_err pulses only if idx != 0.
REQ-020 Any stored digit > 9 SHALL mark the current frame bad; at idx wrap a bad frame pulses frame_err, is not converted, and the flag clears.
REQ-021 At idx wrap of a good frame, the capture buffer SHALL be copied to a conversion buffer in the same cycle and the conversion started.
REQ-022 Conversion SHALL run one digit per clk, MSD first: acc = acc*10 + d, with *10 computed as (acc<<3)+(acc<<1), acc 27 bits (99,999,999 < 2^27); done after DIGITS cycles.
REQ-023 At conversion done, value, digits and value_valid SHALL update in the same cycle; value_valid lasts exactly one clk.
REQ-024 Conversion SHALL use only the conversion buffer; capture of the next frame and clear/abort events during conversion SHALL NOT disturb it.
REQ-025 value/digits SHALL hold between updates; bad or aborted frames SHALL leave them unchanged.
REQ-026 Supported link rate: each clk_in half-period SHALL be >= SYNC_STAGES+2 clk cycles; behaviour is undefined outside this range.
REQ-027 frame_err and value_valid MAY coincide (conversion of frame N finishing as frame N+1 is rejected).

Reset
REQ-028 rst SHALL asynchronously force FSM=IDLE, idx=0, bad flag=0, conversion idle, acc=0, all synchronizer flops=0.
REQ-029 Output reset values: value=0, digits=0, value_valid=0, frame_err=0, locked=0.
REQ-030 Reset asserted mid-frame or mid-conversion SHALL discard all partial data; no value_valid after release until a full new frame after a clear.
REQ-031 After reset release, locked SHALL stay 0 until REQ-017 completes; a stream with no clear SHALL never produce value_valid.

Verification
REQ-032 Clear, stale sample, then digits 1,1,1,1,1,1,1,1 -> one value_valid, value=32'd11111111 (0x00A98AC7), digits=0x11111111, locked=1.
REQ-033 Continuous stream switching to 2,2,2,2,2,2,2,2 with no new clear -> value=32'd22222222 (0x0153158E) on the next wrap, value_valid once per frame.
REQ-034 Frame 9,9,9,9,9,9,9,9 -> value=0x05F5E0FF; next frame containing digit 0xA -> frame_err pulse, value stays 0x05F5E0FF, no value_valid.
REQ-035 cclr_neg low after 3 digits -> frame_err pulse, FSM re-arms, next full frame 0,0,0,0,0,0,4,2 -> value=42, digits=0x00000042.
REQ-036 rst pulse during conversion of 11111111 -> all outputs 0, no value_valid; a stream lacking a clear afterwards never sets locked.

Source files
------------

// File: rtl/led_receiver.sv
// Receives a serial BCD display link, keeps the last good frame as BCD and as binary.
// Latency: SYNC_STAGES+1 clk from a link falling edge to the sample, then DIGITS clk of conversion.
// No backpressure: the link is free-running, and bad or aborted frames are dropped with a frame_err pulse.
module led_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int DIGITS      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_in,
   input  logic        cclr_neg,
   input  logic [3:0]  num,
   output logic [31:0] value,
   output logic [31:0] digits,
   output logic        value_valid,
   output logic        frame_err,
   output logic        locked
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, ARM, RECV} state_t;

   logic [SYNC_STAGES-1:0]       clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0]       cclr_sync_q, cclr_sync_d;
   logic [SYNC_STAGES-1:0][3:0]  num_sync_q, num_sync_d;
   logic                         clk_prev_q, clk_prev_d;
   logic                         clk_s, cclr_s, sample;
   logic [3:0]                   num_s;

   state_t                       state_q, state_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic                         bad_q, bad_d;
   logic [DIGITS-1:0][3:0]       cap_q, cap_d;
   logic                         start;
   logic                         err_q, err_d;
   logic                         locked_q, locked_d;

   logic                         busy_q, busy_d;
   logic [IW-1:0]                cnt_q, cnt_d;
   logic [26:0]                  acc_q, acc_d, acc_nx;
   logic [DIGITS-1:0][3:0]       conv_q, conv_d;
   logic [31:0]                  value_q, value_d;
   logic [31:0]                  digits_q, digits_d;
   logic                         vv_q, vv_d;

   // Places digit 0 in the most significant nibble, zero-extending short frames.
   function automatic logic [31:0] pack_bcd(input logic [DIGITS-1:0][3:0] buf_in);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*(DIGITS-1-i) +: 4] = buf_in[i];
      end
      return r;
   endfunction

   // Synchronizer chains (identical depth keeps the three link signals aligned) and sample detect.
   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], clk_in};
      cclr_sync_d = {cclr_sync_q[SYNC_STAGES-2:0], cclr_neg};
      num_sync_d  = {num_sync_q[SYNC_STAGES-2:0], num};
      clk_s       = clk_sync_q[SYNC_STAGES-1];
      cclr_s      = cclr_sync_q[SYNC_STAGES-1];
      num_s       = num_sync_q[SYNC_STAGES-1];
      clk_prev_d  = clk_s;
      sample      = clk_prev_q & ~clk_s;
   end

   // Receive FSM: frame alignment, digit capture, bad-digit tracking and frame hand-off.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bad_d   = bad_q;
      cap_d   = cap_q;
      err_d   = 1'b0;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample && !cclr_s) state_d = ARM;
         end
         ARM: begin
            // The first sample after the clear carries a stale digit and is dropped.
            if (sample && cclr_s) begin
               state_d = RECV;
               idx_d   = '0;
               bad_d   = 1'b0;
            end
         end
         RECV: begin
            if (sample) begin
               if (!cclr_s) begin
                  state_d = ARM;
                  err_d   = (idx_q != '0);
                  idx_d   = '0;
                  bad_d   = 1'b0;
               end else begin
                  cap_d[idx_q] = num_s;
                  if (idx_q == LAST) begin
                     idx_d = '0;
                     bad_d = 1'b0;
                     if (bad_q || (num_s > 4'd9)) err_d = 1'b1;
                     else                         start = 1'b1;
                  end else begin
                     idx_d = idx_q + IW'(1);
                     bad_d = bad_q | (num_s > 4'd9);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      locked_d = (state_d == RECV);
   end

   // Sequential BCD-to-binary conversion, MSD first, from its own buffer.
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      conv_d   = conv_q;
      value_d  = value_q;
      digits_d = digits_q;
      vv_d     = 1'b0;
      acc_nx   = (acc_q << 3) + (acc_q << 1) + 27'(conv_q[cnt_q]);
      if (start) begin
         conv_d = cap_d;
         busy_d = 1'b1;
         cnt_d  = '0;
         acc_d  = '0;
      end else if (busy_q) begin
         acc_d = acc_nx;
         cnt_d = cnt_q + IW'(1);
         if (cnt_q == LAST) begin
            busy_d   = 1'b0;
            cnt_d    = '0;
            value_d  = 32'(acc_nx);
            digits_d = pack_bcd(conv_q);
            vv_d     = 1'b1;
         end
      end
   end

   // State registers, all cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q  <= '0;
         cclr_sync_q <= '0;
         num_sync_q  <= '0;
         clk_prev_q  <= 1'b0;
         state_q     <= IDLE;
         idx_q       <= '0;
         bad_q       <= 1'b0;
         cap_q       <= '0;
         err_q       <= 1'b0;
         locked_q    <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         conv_q      <= '0;
         value_q     <= '0;
         digits_q    <= '0;
         vv_q        <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         cclr_sync_q <= cclr_sync_d;
         num_sync_q  <= num_sync_d;
         clk_prev_q  <= clk_prev_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         bad_q       <= bad_d;
         cap_q       <= cap_d;
         err_q       <= err_d;
         locked_q    <= locked_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         conv_q      <= conv_d;
         value_q     <= value_d;
         digits_q    <= digits_d;
         vv_q        <= vv_d;
      end
   end

   assign value       = value_q;
   assign digits      = digits_q;
   assign value_valid = vv_q;
   assign frame_err   = err_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_led_receiver.sv
// Directed test of led_receiver: link frames, bad digits, aborts and reset.
// Link half-period is HALF clk cycles; outputs are sampled 1 time unit after a clk rising edge.
// Pulse outputs are counted every falling edge and checked as deltas.
module tb_led_receiver;

   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_in = 1'b0;
   logic        cclr_neg = 1'b1;
   logic [3:0]  num = 4'd0;
   logic [31:0] value, digits;
   logic        value_valid, frame_err, locked;

   int n_vec = 0;
   int n_err = 0;
   int vv_cnt = 0;
   int fe_cnt = 0;
   int vv_base, fe_base;

   led_receiver #(.SYNC_STAGES(2), .DIGITS(8)) dut (
      .clk(clk), .rst(rst), .clk_in(clk_in), .cclr_neg(cclr_neg), .num(num),
      .value(value), .digits(digits), .value_valid(value_valid),
      .frame_err(frame_err), .locked(locked)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (value_valid) vv_cnt++;
      if (frame_err)   fe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One link digit: data changes with the rising edge, receiver samples on the falling edge.
   task automatic send(input logic clr_n, input logic [3:0] d);
      cclr_neg = clr_n;
      num      = d;
      clk_in   = 1'b1;
      repeat (HALF) @(posedge clk);
      clk_in   = 1'b0;
      repeat (HALF) @(posedge clk);
   endtask

   task automatic send_frame(input logic [31:0] bcd);
      logic [31:0] f;
      f = bcd;
      for (int i = 0; i < 8; i++) send(1'b1, f[31-4*i -: 4]);
   endtask

   task automatic settle();
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic mark();
      vv_base = vv_cnt;
      fe_base = fe_cnt;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_value",  value, 32'h0);
      check("reset_digits", digits, 32'h0);
      check("reset_vv",     {31'b0, value_valid}, 32'h0);
      check("reset_ferr",   {31'b0, frame_err}, 32'h0);
      check("reset_locked", {31'b0, locked}, 32'h0);
      rst = 1'b0;
      repeat (3) @(posedge clk);

      // Clear, stale sample, then all ones.
      mark();
      send(1'b0, 4'd0);
      send(1'b1, 4'd7);
      send_frame(32'h1111_1111);
      settle();
      check("ones_value",  value, 32'h00A9_8AC7);
      check("ones_digits", digits, 32'h1111_1111);
      check("ones_vv_cnt", vv_cnt - vv_base, 32'd1);
      check("ones_fe_cnt", fe_cnt - fe_base, 32'd0);
      check("ones_locked", {31'b0, locked}, 32'h1);

      // Continuous stream, no new clear.
      mark();
      send_frame(32'h2222_2222);
      settle();
      check("twos_value",  value, 32'h0153_158E);
      check("twos_digits", digits, 32'h2222_2222);
      check("twos_vv_cnt", vv_cnt - vv_base, 32'd1);

      mark();
      send_frame(32'h9999_9999);
      settle();
      check("nines_value",  value, 32'h05F5_E0FF);
      check("nines_vv_cnt", vv_cnt - vv_base, 32'd1);

      // Frame with a non-BCD digit is rejected.
      mark();
      send_frame(32'h99A9_9999);
      settle();
      check("bad_fe_cnt", fe_cnt - fe_base, 32'd1);
      check("bad_vv_cnt", vv_cnt - vv_base, 32'd0);
      check("bad_value",  value, 32'h05F5_E0FF);

      // Abort after three digits, re-arm, then 00000042.
      mark();
      send(1'b1, 4'd1);
      send(1'b1, 4'd2);
      send(1'b1, 4'd3);
      send(1'b0, 4'd0);
      settle();
      check("abort_fe_cnt", fe_cnt - fe_base, 32'd1);
      check("abort_value",  value, 32'h05F5_E0FF);
      mark();
      send(1'b1, 4'd5);
      send_frame(32'h0000_0042);
      settle();
      check("fortytwo_value",  value, 32'd42);
      check("fortytwo_digits", digits, 32'h0000_0042);
      check("fortytwo_vv_cnt", vv_cnt - vv_base, 32'd1);
      check("fortytwo_fe_cnt", fe_cnt - fe_base, 32'd0);

      // Reset while 11111111 is being converted.
      mark();
      send(1'b0, 4'd0);
      send(1'b1, 4'd0);
      send_frame(32'h1111_1111);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      settle();
      check("rst_value",  value, 32'h0);
      check("rst_digits", digits, 32'h0);
      check("rst_vv_cnt", vv_cnt - vv_base, 32'd0);
      check("rst_locked", {31'b0, locked}, 32'h0);

      // Stream without any clear must never lock or deliver a value.
      mark();
      for (int i = 0; i < 20; i++) send(1'b1, 4'(i % 10));
      settle();
      check("noclr_locked", {31'b0, locked}, 32'h0);
      check("noclr_vv_cnt", vv_cnt - vv_base, 32'd0);
      check("noclr_value",  value, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
